spie_slave: RTL and testbench
=============================

SPIE_SLAVE -- requirements
Module: spie_slave

Interface
REQ-001 The module SHALL have no parameters; datawidth and byte order are run-time inputs.
REQ-002 clk  in  1  system clock; the only clock, and every flop SHALL be clocked by it.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 cs_n  in  1  chip select from the SPI initiator, asynchronous, active low.
REQ-005 sclk  in  1  serial clock from the initiator, asynchronous, idle high.
REQ-006 mosi  in  1  serial data from the initiator, asynchronous.
REQ-007 miso  out  1  serial data to the initiator.
REQ-008 datawidth  in  2  word size: 2'b00 = 8, 2'b10 = 16, 2'b01 = 32 bits; 2'b11 = 8 bits.
REQ-009 msbytefirst  in  1  1 = MSByte first, 0 = LSByte first; MSbit of each byte is always first.
REQ-010 tx_data  in  32  next word to send; only the low W bits are used.
REQ-011 tx_wr  in  1  one-cycle strobe that loads tx_data into the holding register.
REQ-012 tx_empty  out  1  holding register free.
REQ-013 rx_data  out  32  last received word, zero-extended above W bits.
REQ-014 rx_valid  out  1  rx_data unread.
REQ-015 rx_ack  in  1  one-cycle strobe that clears rx_valid.
REQ-016 overrun, underrun  out  1 each  sticky error flags.
REQ-017 clr  in  1  one-cycle strobe that clears overrun and underrun.

Function
REQ-018 cs_n, sclk and mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized values.
REQ-019 Correct operation SHALL be guaranteed when every sclk high and low phase lasts at least 3 clk cycles.
REQ-020 A word SHALL start on cs_n assertion and again after each completed word while cs_n stays low.
REQ-021 At word start, the shift register SHALL load the holding register and set tx_empty=1; if tx_empty was already 1, it SHALL load all-ones and set underrun=1.
REQ-022 On each synchronized sclk rising edge, the module SHALL sample mosi into the receive shift path and increment bitcnt.
REQ-023 On each sclk falling edge with bitcnt != 0, the transmit shift path SHALL advance one bit; the first falling edge of a word SHALL NOT shift.
REQ-024 The module SHALL present the first bit of each word on miso before the first falling edge of that word.
REQ-025 Word completion is the rising edge on which bitcnt reaches W; at completion:
  - rx_data SHALL be updated in the following clk cycle;
  - rx_valid SHALL be set to 1;
  - bitcnt SHALL return to 0;
  - the next word SHALL start (per REQ-020/021).
REQ-026 Completion with rx_valid already 1 SHALL overwrite rx_data and set overrun=1.
REQ-027 Bit order, with serial bit index i = 0 first:
  - msbytefirst=1: i maps to data[W-1-i];
  - msbytefirst=0: i maps to data[8*(i/8) + 7 - i%8].
  Both the transmit and receive directions SHALL use this mapping.
REQ-028 cs_n deassertion mid-word SHALL abort the word:
  - the partial word SHALL be discarded, with no rx_valid and no overrun;
  - bitcnt SHALL be cleared;
  - the holding register SHALL be unaffected if it was refilled after the load.
REQ-029 miso SHALL be 1 whenever synchronized cs_n is high.
REQ-030 tx_wr SHALL overwrite the holding register at any time and set tx_empty=0.
REQ-031 If tx_wr coincides with a word-start load, the new data SHALL be taken by the load, leaving tx_empty=1.
REQ-032 If rx_ack coincides with word completion, rx_valid SHALL end at 1, with no overrun.
REQ-033 clr and a simultaneous new error in the same cycle SHALL leave the flag set.
REQ-034 datawidth and msbytefirst SHALL be held stable while cs_n is low; behaviour on change mid-word is undefined.

Reset
REQ-035 While rst_n=0, the outputs SHALL be:
  - miso=1, tx_empty=1;
  - rx_data=0, rx_valid=0;
  - overrun=0, underrun=0.
  bitcnt, shift register and holding register SHALL be 0; the synchronizers SHALL be preset to cs_n=1 and sclk=1.
REQ-036 Reset assertion mid-word SHALL abandon the word immediately.
REQ-037 After rst_n release, the first word SHALL start only on a new cs_n falling edge.

Verification
REQ-038 W=8: tx_wr with 0xA5; initiator sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x0000003C; rx_valid=1; tx_empty=1.
REQ-039 W=16, msbytefirst=0: tx_data=0x1234; initiator sends bytes 0xCD then 0xAB -> miso bytes 0x34 then 0x12; rx_data=0x0000ABCD.
REQ-040 W=32, msbytefirst=1, two back-to-back words with no tx_wr before the second:
  - initiator sends 0xDEADBEEF then 0x01020304, no rx_ack;
  - second word miso is all ones;
  - underrun=1, overrun=1;
  - rx_data=0x01020304.
REQ-041 W=8: cs_n raised after 5 bits -> rx_valid stays 0; the next full word 0x81 is received as 0x81.
REQ-042 W=8: rst_n pulsed low mid-word -> all outputs at reset values; the next full word is received correctly.
REQ-043 clr asserted in the same cycle as a new underrun -> underrun=1; clr alone -> 0.

Source files
------------

// File: rtl/spie_if.sv
// spie_if: SPI serial lines plus host-side word/strobe bus of the SPI slave
interface spie_if;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [1:0]  datawidth;
  logic        msbytefirst;
  logic [31:0] tx_data;
  logic        tx_wr;
  logic        tx_empty;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        overrun;
  logic        underrun;
  logic        clr;
  modport slave (
    input  cs_n, sclk, mosi, datawidth, msbytefirst, tx_data, tx_wr, rx_ack, clr,
    output miso, tx_empty, rx_data, rx_valid, overrun, underrun
  );
  modport master (
    output cs_n, sclk, mosi, datawidth, msbytefirst, tx_data, tx_wr, rx_ack, clr,
    input  miso, tx_empty, rx_data, rx_valid, overrun, underrun
  );
endinterface

// File: rtl/spie_slave.sv
// spie_slave: oversampled SPI slave (idle-high sclk) with run-time word size and byte order
module spie_slave (
  input  logic   clk,
  input  logic   rst_n,
  spie_if.slave  bus
);
  logic [1:0]  cs_s_q, sck_s_q, mosi_s_q;
  logic        cs_p_q, sck_p_q;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [31:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, hold_q, hold_d, rx_data_q, rx_data_d;
  logic        tx_empty_q, tx_empty_d, rx_valid_q, rx_valid_d, ovr_q, ovr_d, und_q, und_d;
  logic        cs, sck, mosi, sck_rise, sck_fall, done, start, starve;
  logic [5:0]  w;
  logic [31:0] rx_cur;

  // Serial index <-> data bit mapping; it is its own inverse, so one function
  // serves both the transmit load and the receive unload. Bits >= W read as 0.
  function automatic logic [31:0] perm(input logic [31:0] d, input logic [5:0] wl, input logic msb);
    logic [31:0] r;
    logic [4:0]  k5;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      k5 = 5'(k);
      if (6'(k) < wl) r[k] = d[msb ? 5'(wl - 6'd1 - {1'b0, k5}) : {k5[4:3], ~k5[2:0]}];
    end
    return r;
  endfunction

  assign cs       = cs_s_q[1];
  assign sck      = sck_s_q[1];
  assign mosi     = mosi_s_q[1];
  assign w        = bus.datawidth == 2'b10 ? 6'd16 : bus.datawidth == 2'b01 ? 6'd32 : 6'd8;
  assign sck_rise = ~cs & sck & ~sck_p_q;
  assign sck_fall = ~cs & ~sck & sck_p_q;
  assign done     = sck_rise & (bitcnt_q + 6'd1 == w);
  assign start    = ~cs & (cs_p_q | done);
  assign starve   = start & tx_empty_q & ~bus.tx_wr;

  assign bus.miso     = cs | tx_sh_q[0];
  assign bus.tx_empty = tx_empty_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.overrun  = ovr_q;
  assign bus.underrun = und_q;

  // Next state: shift paths in serial order, holding register, status flags
  always_comb begin
    rx_cur = rx_sh_q;
    rx_cur[bitcnt_q[4:0]] = mosi;
    bitcnt_d   = (cs | done) ? 6'd0 : sck_rise ? bitcnt_q + 6'd1 : bitcnt_q;
    rx_sh_d    = sck_rise ? rx_cur : rx_sh_q;
    tx_sh_d    = start ? (starve ? '1 : perm(bus.tx_wr ? bus.tx_data : hold_q, w, bus.msbytefirst))
               : (sck_fall && bitcnt_q != 6'd0) ? {1'b1, tx_sh_q[31:1]} : tx_sh_q;
    hold_d     = bus.tx_wr ? bus.tx_data : hold_q;
    tx_empty_d = start | (~bus.tx_wr & tx_empty_q);
    rx_data_d  = done ? perm(rx_cur, w, bus.msbytefirst) : rx_data_q;
    rx_valid_d = done | (rx_valid_q & ~bus.rx_ack);
    ovr_d      = (ovr_q & ~bus.clr) | (done & rx_valid_q & ~bus.rx_ack);
    und_d      = (und_q & ~bus.clr) | starve;
  end

  // Two-flop synchronizers and previous-value flops for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s_q   <= 2'b11;
      sck_s_q  <= 2'b11;
      mosi_s_q <= 2'b00;
      cs_p_q   <= 1'b1;
      sck_p_q  <= 1'b1;
    end else begin
      cs_s_q   <= {cs_s_q[0], bus.cs_n};
      sck_s_q  <= {sck_s_q[0], bus.sclk};
      mosi_s_q <= {mosi_s_q[0], bus.mosi};
      cs_p_q   <= cs;
      sck_p_q  <= sck;
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_q   <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      hold_q     <= '0;
      rx_data_q  <= '0;
      tx_empty_q <= 1'b1;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      bitcnt_q   <= bitcnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      hold_q     <= hold_d;
      rx_data_q  <= rx_data_d;
      tx_empty_q <= tx_empty_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      und_q      <= und_d;
    end
  end
endmodule

// File: tb/tb_spie_slave.sv
// tb_spie_slave: SPI initiator driver with a word-level reference model of the slave
module tb_spie_slave;
  localparam int PH = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  spie_if bus();
  spie_slave dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  logic [31:0] m_hold, m_cur, m_rxd, col;
  bit m_empty, m_rxv, m_ovr, m_und;
  int w;
  bit msb;

  function automatic int idx(int i, int wl, bit mb);
    return mb ? wl - 1 - i : 8 * (i / 8) + 7 - i % 8;
  endfunction

  function automatic int wbits(logic [1:0] dw);
    return dw == 2'b10 ? 16 : dw == 2'b01 ? 32 : 8;
  endfunction

  function automatic logic [31:0] mask(logic [31:0] v, int wl);
    return wl == 32 ? v : v & ((32'd1 << wl) - 32'd1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("tx_empty", bus.tx_empty, m_empty);
      check("rx_valid", bus.rx_valid, m_rxv);
      check("rx_data", bus.rx_data, m_rxd);
      check("overrun", bus.overrun, m_ovr);
      check("underrun", bus.underrun, m_und);
      if (bus.cs_n) check("miso_idle", bus.miso, 1);
    end
  end

  task automatic ticks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    ticks(6);
    chk_en = 1'b1;
  endtask

  task automatic model_reset();
    m_hold = '0; m_cur = '0; m_rxd = '0;
    m_empty = 1'b1; m_rxv = 1'b0; m_ovr = 1'b0; m_und = 1'b0;
  endtask

  task automatic model_start();
    m_cur = m_empty ? '1 : m_hold;
    if (m_empty) m_und = 1'b1;
    m_empty = 1'b1;
  endtask

  task automatic host(bit wr, logic [31:0] d, bit ack, bit cl);
    @(negedge clk);
    chk_en = 1'b0;
    bus.tx_wr = wr; bus.tx_data = d; bus.rx_ack = ack; bus.clr = cl;
    @(negedge clk);
    bus.tx_wr = 1'b0; bus.rx_ack = 1'b0; bus.clr = 1'b0;
    if (wr) begin m_hold = d; m_empty = 1'b0; end
    if (ack) m_rxv = 1'b0;
    if (cl) begin m_ovr = 1'b0; m_und = 1'b0; end
  endtask

  task automatic set_cfg(logic [1:0] dw, bit mb);
    bus.datawidth = dw; bus.msbytefirst = mb;
    w = wbits(dw); msb = mb;
  endtask

  task automatic cs_down();
    @(negedge clk);
    chk_en = 1'b0;
    bus.cs_n = 1'b0;
    model_start();
    settle();
  endtask

  task automatic cs_up();
    @(negedge clk);
    chk_en = 1'b0;
    bus.cs_n = 1'b1;
    settle();
  endtask

  // Send nb bits of mo (nb < w aborts later via cs_up); inj: bit0 tx_wr, bit1 rx_ack mid-word
  task automatic word(logic [31:0] mo, int nb, int inj);
    logic [31:0] exp_tx;
    exp_tx = m_cur;
    col = '0;
    chk_en = 1'b0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      bus.sclk = 1'b0;
      bus.mosi = mo[idx(i, w, msb)];
      if (i == 2 && inj != 0) begin
        host(inj[0], $urandom, inj[1], 1'b0);
        ticks(PH - 2);
      end else ticks(PH);
      check("miso_bit", bus.miso, exp_tx[idx(i, w, msb)]);
      col = {col[30:0], bus.miso};
      bus.sclk = 1'b1;
      ticks(PH);
    end
    if (nb == w) begin
      if (m_rxv) m_ovr = 1'b1;
      m_rxd = mask(mo, w);
      m_rxv = 1'b1;
      model_start();
    end
    settle();
  endtask

  initial begin
    int nw;
    bus.cs_n = 1'b1; bus.sclk = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_wr = 1'b0; bus.rx_ack = 1'b0; bus.clr = 1'b0;
    set_cfg(2'b00, 1'b1);
    model_reset();
    ticks(3);
    check("rst_miso", bus.miso, 1);
    check("rst_tx_empty", bus.tx_empty, 1);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_underrun", bus.underrun, 0);
    rst_n = 1'b1;
    settle();

    host(1'b1, 32'hA5, 1'b0, 1'b0); settle();
    cs_down();
    word(32'h3C, 8, 0);
    check("w8_miso", col[7:0], 32'hA5);
    check("w8_rx_data", bus.rx_data, 32'h3C);
    check("w8_rx_valid", bus.rx_valid, 1);
    check("w8_tx_empty", bus.tx_empty, 1);
    cs_up();
    host(1'b0, 0, 1'b1, 1'b1); settle();

    set_cfg(2'b10, 1'b0);
    host(1'b1, 32'h1234, 1'b0, 1'b0); settle();
    cs_down();
    word(32'hABCD, 16, 0);
    check("w16_lsb_miso", col[15:0], 32'h3412);
    check("w16_lsb_rx_data", bus.rx_data, 32'hABCD);
    cs_up();
    host(1'b0, 0, 1'b1, 1'b1); settle();

    set_cfg(2'b01, 1'b1);
    host(1'b1, 32'hCAFEF00D, 1'b0, 1'b0); settle();
    cs_down();
    word(32'hDEADBEEF, 32, 0);
    word(32'h01020304, 32, 0);
    check("w32_starved_miso", col, 32'hFFFFFFFF);
    check("w32_underrun", bus.underrun, 1);
    check("w32_overrun", bus.overrun, 1);
    check("w32_rx_data", bus.rx_data, 32'h01020304);
    cs_up();
    host(1'b0, 0, 1'b1, 1'b1); settle();

    set_cfg(2'b00, 1'b1);
    host(1'b1, $urandom, 1'b0, 1'b0); settle();
    cs_down();
    word($urandom, 5, 0);
    cs_up();
    check("abort_rx_valid", bus.rx_valid, 0);
    check("abort_miso", bus.miso, 1);
    host(1'b1, $urandom, 1'b0, 1'b0); settle();
    cs_down();
    word(32'h81, 8, 0);
    check("after_abort_rx", bus.rx_data, 32'h81);
    cs_up();
    host(1'b0, 0, 1'b1, 1'b1); settle();

    host(1'b1, 32'h66, 1'b0, 1'b0); settle();
    cs_down();
    word(32'h99, 3, 0);
    @(negedge clk);
    chk_en = 1'b0;
    rst_n = 1'b0;
    ticks(1);
    check("midrst_miso", bus.miso, 1);
    check("midrst_tx_empty", bus.tx_empty, 1);
    check("midrst_rx_data", bus.rx_data, 0);
    check("midrst_rx_valid", bus.rx_valid, 0);
    check("midrst_overrun", bus.overrun, 0);
    check("midrst_underrun", bus.underrun, 0);
    bus.cs_n = 1'b1; bus.sclk = 1'b1;
    model_reset();
    ticks(2);
    rst_n = 1'b1;
    settle();
    host(1'b1, 32'h5A, 1'b0, 1'b0); settle();
    cs_down();
    word(32'hC3, 8, 0);
    check("after_rst_rx", bus.rx_data, 32'hC3);
    cs_up();
    host(1'b0, 0, 1'b1, 1'b1); settle();

    @(negedge clk);
    chk_en = 1'b0;
    bus.cs_n = 1'b0;
    model_start();
    ticks(2);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    settle();
    check("clr_vs_underrun", bus.underrun, 1);
    cs_up();
    host(1'b0, 0, 1'b0, 1'b1); settle();
    check("clr_alone", bus.underrun, 0);

    for (int s = 0; s < 16; s++) begin
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) host(1'b1, $urandom, 1'b0, 1'b0);
      if ($urandom_range(0, 1) != 0) host(1'b0, 0, 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) host(1'b0, 0, 1'b0, 1'b1);
      settle();
      cs_down();
      nw = int'($urandom_range(1, 3));
      for (int j = 0; j < nw; j++) word($urandom, w, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) word($urandom, int'($urandom_range(1, w - 1)), 0);
      cs_up();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
